i2s_tx_shifter: RTL and testbench
=================================

# i2s_tx_shifter

Transmit serializer for the I2S transceiver. It sits directly downstream of `ws_control` and the Tx FIFO. It consumes the `Tx_ren`/`del_Tx_ren` enables, pops one sample per channel slot from the FIFO, and shifts it out MSB-first on the serial data line, aligned to the word-select timing of the selected standard. Empty-FIFO underruns are flagged, and the output freezes on `stop`.

## Interface
- `DATA_W`, 32: FIFO word width and maximum slot length in bits.
- `sclk`  in  1  serial bit clock; all state updates on falling edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the falling edge of `sclk`.
- `frame_size`  in  frame_size_t  slot length: `f16bits` (16) or `f32bits` (32).
- `data_len`  in  data_len_t  valid sample bits: `d16`, `d24`, `d32`. Must not exceed the slot length.
- `standard`  in  standard_t  `I2S` (Philips, 1-bit delay) or `MSB` (left-justified).
- `stop`  in  1  freeze: counter, shifter and FSM hold; `sd` holds.
- `tx_ren`  in  1  undelayed slot enable from `ws_control`.
- `del_tx_ren`  in  1  one-cycle-delayed slot enable from `ws_control`.
- `fifo_data`  in  DATA_W  first-word-fall-through head of Tx FIFO; sample left-justified.
- `fifo_empty`  in  1  Tx FIFO empty.
- `fifo_rd`  out  1  one-cycle pop strobe.
- `sd`  out  1  serial data, equal to `shreg[DATA_W-1]`.
- `underrun`  out  1  sticky; set on a load while empty; cleared only by `rst`.
- `bit_cnt`  out  5  current bit index within the slot.

## Operation
- `en = (standard==I2S) ? del_tx_ren : tx_ren`.
- FSM states are `IDLE`, `SHIFT`, `HOLD`.
- **IDLE**
  - `shreg=0`, `bit_cnt=0`, `fifo_rd=0`.
  - On a falling edge with `en=1` and `stop=0`, perform a LOAD and go to `SHIFT`.
- **SHIFT**
  - Each edge: `shreg <<= 1` (zero fill), `bit_cnt++`.
  - When `bit_cnt == slot_len-1`: if `en=1`, LOAD the next slot and wrap `bit_cnt` to 0; else go to `IDLE`.
  - `en` dropping mid-slot (`bit_cnt < slot_len-1`) aborts to `IDLE` on that edge. No pop, `shreg` cleared.
- **HOLD**
  - Entered from `SHIFT` whenever `stop=1`; nothing changes while there.
  - On `stop=0`, return to `SHIFT` and resume at the held `bit_cnt`.
  - `stop=1` in `IDLE` blocks the start.
- **LOAD**
  - `fifo_empty=0`:
    - `shreg[DATA_W-1 -: slot_len] = fifo_data[DATA_W-1 -: slot_len]`.
    - Bits below `data_len` are masked to 0.
    - `fifo_rd=1` for exactly that cycle.
  - `fifo_empty=1`: load all zeros (see Configuration), `fifo_rd=0`, set `underrun`.
- **Width rule:** with `f16bits`, `bit_cnt[4]` stays 0 and only `fifo_data[31:16]` is used.
- **Simultaneous events:**
  - `rst` overrides everything.
  - `stop` overrides a LOAD: no pop occurs during `stop`, and a pending LOAD executes on the first edge after `stop` clears.

## Timing
- **Reset values:** `sd=0`, `fifo_rd=0`, `underrun=0`, `bit_cnt=0`, state `IDLE`.
- **Latency:** the MSB appears on `sd` immediately after the first falling edge that samples `en=1`, i.e. one bit-clock after `en` asserts. In `I2S` mode that is two edges after `tx_ren`.
- One pop per slot, at most.
  - 32-bit stereo: 2 pops per 64 cycles.
  - 16-bit: 1 pop every 16 cycles.
- Back-to-back slots have no gap: the last bit of slot N is followed on the next edge by the MSB of slot N+1.
- `fifo_rd` is registered and asserts in the cycle the new word is on `sd`. The FIFO advances its head on that edge.

## Configuration
- `TX_UNDERRUN_REPEAT_EN`:
  - **Defined:** an underrun LOAD reloads the last successfully popped word (kept in a `last_word` register, reset 0). `underrun` still sets.
  - **Undefined:** an underrun LOAD shifts zeros and no `last_word` register exists.

## Structure
- `ctrl_pkg` already holds `frame_size_t` and `standard_t`. Add `data_len_t` (`d16`, `d24`, `d32`) and `tx_state_t` (`IDLE`, `SHIFT`, `HOLD`).
- `ctrl_pkg` also gets a function returning `slot_len` from `frame_size`.
- One natural sub-module: `i2s_bit_counter`. It contains the slot counter with wrap, hold and clear; it reports `bit_cnt` and `last_bit`.

## Test plan
- **MSB mode, 32-bit frame, data_len=d32:** `fifo_data=32'hA5A5_0F0F` then `32'h8000_0001`, `tx_ren` high for 64 cycles → `sd` streams `A5A50F0F` then `80000001` MSB-first with no gap; `fifo_rd` pulses at cycles 0 and 32.
- **I2S mode:** same stimulus → `sd` is identical but starts one edge later, tracking `del_tx_ren`.
- **data_len=d24, f32bits, `fifo_data=32'hFFFF_FFFF`:** → 24 ones then 8 zeros per slot.
- **Underrun:** `fifo_empty=1` at the second slot → slot 2 is all zeros, or repeats slot 1 with the macro defined; `underrun=1` and stays set; no `fifo_rd` in that slot.
- **Stop:** `stop` held for 5 cycles at `bit_cnt=10` → `sd` and `bit_cnt` frozen for those cycles, resuming at bit 11; total pops unchanged.
- **Abort and reset:** `tx_ren` drops at `bit_cnt=7` → `IDLE`, `sd=0`, no extra pop. A `rst` pulse mid-slot → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S transceiver.
// Frame/standard enums, Tx data length, serializer state and slot helpers.
package ctrl_pkg;

  typedef enum logic {f16bits, f32bits} frame_size_t;
  typedef enum logic {I2S, MSB} standard_t;
  typedef enum logic [1:0] {d16, d24, d32} data_len_t;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} tx_state_t;

  function automatic logic [5:0] slot_len(input frame_size_t fs);
    return (fs == f32bits) ? 6'd32 : 6'd16;
  endfunction

  function automatic logic [5:0] data_bits(input data_len_t dl);
    case (dl)
      d16:     return 6'd16;
      d24:     return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/i2s_bit_counter.sv
// Bit index within a Tx slot: clears, advances with wrap, or holds.
// Updates on the falling edge of the bit clock.
module i2s_bit_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  input  logic [4:0] last_idx,
  output logic [4:0] bit_cnt,
  output logic       last_bit
);

  logic [4:0] cnt_q;
  logic [4:0] cnt_d;

  assign last_bit = (cnt_q == last_idx);
  assign bit_cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = last_bit ? 5'd0 : cnt_q + 5'd1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2s_tx_shifter.sv
// I2S transmit serializer: pops one FIFO word per slot, shifts MSB-first.
// TX_UNDERRUN_REPEAT_EN: underrun slots replay the last popped word.
module i2s_tx_shifter
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              sclk,
  input  logic              rst,
  input  frame_size_t       frame_size,
  input  data_len_t         data_len,
  input  standard_t         standard,
  input  logic              stop,
  input  logic              tx_ren,
  input  logic              del_tx_ren,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic              sd,
  output logic              underrun,
  output logic [4:0]        bit_cnt
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              underrun_q, underrun_d;

  logic              en;
  logic              running;
  logic              last_bit;
  logic              do_load;
  logic              go_idle;
  logic [5:0]        slen;
  logic [5:0]        dbits;
  logic [5:0]        nbits;
  logic [4:0]        last_idx;
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] src;

  assign en       = (standard == I2S) ? del_tx_ren : tx_ren;
  assign running  = (state_q == SHIFT) || (state_q == HOLD);
  assign slen     = slot_len(frame_size);
  assign dbits    = data_bits(data_len);
  assign last_idx = slen[4:0] - 5'd1;

  // Keep only the top min(slot, data) bits of the loaded word
  assign nbits = (dbits < slen) ? dbits : slen;
  assign ones  = '1;
  assign mask  = ~(ones >> nbits);

  assign do_load = !stop && en &&
                   ((state_q == IDLE) || (running && last_bit));
  assign go_idle = !stop && !do_load && (!running || !en);

`ifdef TX_UNDERRUN_REPEAT_EN
  logic [DATA_W-1:0] last_word_q, last_word_d;

  assign src = fifo_empty ? last_word_q : fifo_data;

  always_comb begin
    last_word_d = last_word_q;
    if (do_load && !fifo_empty) begin
      last_word_d = fifo_data;
    end
  end

  always_ff @(negedge sclk) begin
    if (rst) begin
      last_word_q <= '0;
    end else begin
      last_word_q <= last_word_d;
    end
  end
`else
  assign src = fifo_empty ? '0 : fifo_data;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    fifo_rd_d  = 1'b0;
    underrun_d = underrun_q;
    unique case (1'b1)
      stop: begin
        if (running) state_d = HOLD;
      end
      do_load: begin
        state_d    = SHIFT;
        shreg_d    = src & mask;
        fifo_rd_d  = !fifo_empty;
        underrun_d = underrun_q | fifo_empty;
      end
      go_idle: begin
        state_d = IDLE;
        shreg_d = '0;
      end
      default: begin
        state_d = SHIFT;
        shreg_d = shreg_q << 1;
      end
    endcase
  end

  always_ff @(negedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      fifo_rd_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      fifo_rd_q  <= fifo_rd_d;
      underrun_q <= underrun_d;
    end
  end

  i2s_bit_counter u_cnt (
    .clk      (sclk),
    .rst      (rst),
    .clr      (go_idle),
    .adv      (running && !stop && en),
    .last_idx (last_idx),
    .bit_cnt  (bit_cnt),
    .last_bit (last_bit)
  );

  assign sd       = shreg_q[DATA_W-1];
  assign fifo_rd  = fifo_rd_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_shifter.sv
// Directed bench for i2s_tx_shifter with a per-bit expectation queue
// and a first-word-fall-through FIFO model.
module tb_i2s_tx_shifter;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       sd;
    logic       rd;
    logic [4:0] cnt;
  } exp_t;

  logic        sclk = 1'b0;
  logic        rst;
  frame_size_t frame_size;
  data_len_t   data_len;
  standard_t   standard;
  logic        stop;
  logic        tx_ren;
  logic        del_tx_ren;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        sd;
  logic        underrun;
  logic [4:0]  bit_cnt;

  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  logic [31:0] fq[$];
  exp_t        eq[$];
  logic [31:0] w;

  always #5 sclk = ~sclk;

  i2s_tx_shifter #(.DATA_W(32)) dut (
    .sclk       (sclk),
    .rst        (rst),
    .frame_size (frame_size),
    .data_len   (data_len),
    .standard   (standard),
    .stop       (stop),
    .tx_ren     (tx_ren),
    .del_tx_ren (del_tx_ren),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .sd         (sd),
    .underrun   (underrun),
    .bit_cnt    (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fq[0];
  endtask

  task automatic tick();
    @(negedge sclk);
    #1;
    if (fifo_rd === 1'b1) begin
      pops++;
      if (fq.size() > 0) fq.delete(0);
    end
    del_tx_ren = tx_ren;
    refresh();
  endtask

  task automatic push(input logic s, input logic r, input logic [4:0] c);
    exp_t e;
    e.sd  = s;
    e.rd  = r;
    e.cnt = c;
    eq.push_back(e);
  endtask

  task automatic push_bits(input logic [31:0] wd, input int dbits,
                           input int from, input int to, input logic rd0);
    for (int i = from; i <= to; i++) begin
      push((i < dbits) ? wd[31-i] : 1'b0, rd0 && (i == 0), 5'(i));
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 5'd0);
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (eq.size() == 0) begin
        fails++;
        $error("FAIL %s[%0d] scoreboard underflow", tag, i);
      end else begin
        e = eq.pop_front();
        check($sformatf("%s[%0d].sd", tag, i), 32'(sd), 32'(e.sd));
        check($sformatf("%s[%0d].rd", tag, i), 32'(fifo_rd), 32'(e.rd));
        check($sformatf("%s[%0d].cnt", tag, i), 32'(bit_cnt), 32'(e.cnt));
      end
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tx_ren = 1'b0;
    stop   = 1'b0;
    fq.delete();
    eq.delete();
    refresh();
    tick();
    rst  = 1'b0;
    pops = 0;
  endtask

  initial begin
    rst        = 1'b1;
    stop       = 1'b0;
    tx_ren     = 1'b0;
    del_tx_ren = 1'b0;
    frame_size = f32bits;
    data_len   = d32;
    standard   = MSB;
    refresh();

    // reset state
    do_reset();
    check("rst.sd", 32'(sd), 32'd0);
    check("rst.rd", 32'(fifo_rd), 32'd0);
    check("rst.cnt", 32'(bit_cnt), 32'd0);
    check("rst.underrun", 32'(underrun), 32'd0);

    // MSB-justified, two back-to-back 32-bit slots
    fq = '{32'hA5A5_0F0F, 32'h8000_0001};
    refresh();
    push_bits(32'hA5A5_0F0F, 32, 0, 31, 1'b1);
    push_bits(32'h8000_0001, 32, 0, 31, 1'b1);
    push_idle(1);
    tx_ren = 1'b1;
    run(64, "msb");
    tx_ren = 1'b0;
    run(1, "msb_end");
    check("msb.pops", 32'(pops), 32'd2);

    // Philips: same stream, one edge later
    do_reset();
    standard = I2S;
    fq = '{32'hA5A5_0F0F, 32'h8000_0001};
    refresh();
    push_idle(1);
    push_bits(32'hA5A5_0F0F, 32, 0, 31, 1'b1);
    push_bits(32'h8000_0001, 32, 0, 31, 1'b1);
    push_idle(1);
    tx_ren = 1'b1;
    run(64, "i2s");
    tx_ren = 1'b0;
    run(2, "i2s_end");
    check("i2s.pops", 32'(pops), 32'd2);

    // 24 valid bits in a 32-bit slot
    do_reset();
    standard = MSB;
    data_len = d24;
    fq = '{32'hFFFF_FFFF};
    refresh();
    push_bits(32'hFFFF_FFFF, 24, 0, 31, 1'b1);
    push_idle(1);
    tx_ren = 1'b1;
    run(32, "d24");
    tx_ren = 1'b0;
    run(1, "d24_end");

    // 16-bit frame uses only the upper half word
    do_reset();
    frame_size = f16bits;
    data_len   = d16;
    fq = '{32'h1234_ABCD, 32'h8001_FFFF};
    refresh();
    push_bits(32'h1234_ABCD, 16, 0, 15, 1'b1);
    push_bits(32'h8001_FFFF, 16, 0, 15, 1'b1);
    push_idle(1);
    tx_ren = 1'b1;
    run(32, "f16");
    tx_ren = 1'b0;
    run(1, "f16_end");
    check("f16.pops", 32'(pops), 32'd2);

    // underrun on the second slot
    do_reset();
    frame_size = f32bits;
    data_len   = d32;
    fq = '{32'h1357_9BDF};
    refresh();
    push_bits(32'h1357_9BDF, 32, 0, 31, 1'b1);
`ifdef TX_UNDERRUN_REPEAT_EN
    push_bits(32'h1357_9BDF, 32, 0, 31, 1'b0);
`else
    push_bits(32'h0000_0000, 32, 0, 31, 1'b0);
`endif
    push_idle(1);
    tx_ren = 1'b1;
    run(32, "ur1");
    check("ur.before", 32'(underrun), 32'd0);
    run(32, "ur2");
    check("ur.set", 32'(underrun), 32'd1);
    tx_ren = 1'b0;
    run(1, "ur_end");
    check("ur.sticky", 32'(underrun), 32'd1);
    check("ur.pops", 32'(pops), 32'd1);

    // reset mid-slot, underrun still set from above
    fq = '{32'hC3C3_3C3C};
    refresh();
    push_bits(32'hC3C3_3C3C, 32, 0, 4, 1'b1);
    tx_ren = 1'b1;
    run(5, "mid");
    rst    = 1'b1;
    tx_ren = 1'b0;
    tick();
    rst = 1'b0;
    check("mrst.sd", 32'(sd), 32'd0);
    check("mrst.rd", 32'(fifo_rd), 32'd0);
    check("mrst.cnt", 32'(bit_cnt), 32'd0);
    check("mrst.underrun", 32'(underrun), 32'd0);

    // stop blocks the start, then freezes mid-slot at bit 10
    do_reset();
    w  = 32'hF0F0_5A5A;
    fq = '{32'hF0F0_5A5A, 32'h1111_2222};
    refresh();
    push_idle(2);
    push_bits(w, 32, 0, 10, 1'b1);
    for (int i = 0; i < 5; i++) push(w[21], 1'b0, 5'd10);
    push_bits(w, 32, 11, 31, 1'b0);
    push_idle(1);
    stop   = 1'b1;
    tx_ren = 1'b1;
    run(2, "stop_idle");
    stop = 1'b0;
    run(11, "stop_a");
    stop = 1'b1;
    run(5, "stop_hold");
    stop = 1'b0;
    run(21, "stop_b");
    tx_ren = 1'b0;
    run(1, "stop_end");
    check("stop.pops", 32'(pops), 32'd1);
    check("stop.fifo_left", 32'(fq.size()), 32'd1);

    // enable drops at bit 7
    do_reset();
    fq = '{32'h6789_ABCD, 32'h1234_5678};
    refresh();
    push_bits(32'h6789_ABCD, 32, 0, 7, 1'b1);
    push_idle(2);
    tx_ren = 1'b1;
    run(8, "abort");
    tx_ren = 1'b0;
    run(2, "abort_idle");
    check("abort.pops", 32'(pops), 32'd1);
    check("abort.fifo_left", 32'(fq.size()), 32'd1);

    check("sb.drain", 32'(eq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
